// File: rtl/lot_occupancy.sv
// Parking-lot occupancy counter: saturating count from enter/exit pulses, sticky
// over/underflow flags, peak tracking and a registered two-digit BCD view of the count.
module lot_occupancy #(
  parameter int  CAPACITY = 16,
  localparam int CW       = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter,
  input  logic          exit,
  input  logic          clr_err,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf_err,
  output logic          unf_err,
  output logic [CW-1:0] peak,
  output logic [3:0]    bcd_tens,
  output logic [3:0]    bcd_ones
);

  localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } status_t;

  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] peak_reg, peak_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;
  logic [3:0]    tens_reg, tens_next;
  logic [3:0]    ones_reg, ones_next;
  logic          ovf_set;
  logic          unf_set;
  logic [7:0]    bcd_work;
  status_t       status;

  // Occupancy update; enter and exit together cancel and never raise an error.
  always_comb begin
    count_next = count_reg;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    unique case ({enter, exit})
      2'b10: begin
        if (count_reg == CAP_C) ovf_set = 1'b1;
        else                    count_next = count_reg + 1'b1;
      end
      2'b01: begin
        if (count_reg == '0) unf_set = 1'b1;
        else                 count_next = count_reg - 1'b1;
      end
      default: count_next = count_reg;
    endcase
  end

  // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    ovf_next  = ovf_set | (ovf_reg & ~clr_err);
    unf_next  = unf_set | (unf_reg & ~clr_err);
    peak_next = (count_next > peak_reg) ? count_next : peak_reg;
  end

  // Double-dabble of the next count; the tens digit stays below 5 for counts up to 99.
  always_comb begin
    bcd_work = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      if (bcd_work[3:0] >= 4'd5) bcd_work[3:0] = bcd_work[3:0] + 4'd3;
      if (bcd_work[7:4] >= 4'd5) bcd_work[7:4] = bcd_work[7:4] + 4'd3;
      bcd_work = {bcd_work[6:0], count_next[i]};
    end
    tens_next = bcd_work[7:4];
    ones_next = bcd_work[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      peak_reg  <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
    end else begin
      count_reg <= count_next;
      peak_reg  <= peak_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
    end
  end

  // Three-way lot status decoded straight from the registered count.
  always_comb begin
    if (count_reg == '0)        status = ST_EMPTY;
    else if (count_reg == CAP_C) status = ST_FULL;
    else                         status = ST_PARTIAL;
  end

  assign full     = (status == ST_FULL);
  assign empty    = (status == ST_EMPTY);
  assign count    = count_reg;
  assign peak     = peak_reg;
  assign ovf_err  = ovf_reg;
  assign unf_err  = unf_reg;
  assign bcd_tens = tens_reg;
  assign bcd_ones = ones_reg;

endmodule

// File: tb/tb_lot_occupancy.sv
// Directed bench for lot_occupancy: a CAPACITY=16 instance and a CAPACITY=3 instance.
module tb_lot_occupancy;

  logic       clk = 1'b0;
  logic       reset, enter, exit, clr_err;
  logic [4:0] count, peak;
  logic       full, empty, ovf_err, unf_err;
  logic [3:0] bcd_tens, bcd_ones;

  logic       reset3, enter3, exit3, clr3;
  logic [1:0] count3, peak3;
  logic       full3, empty3, ovf3, unf3;
  logic [3:0] tens3, ones3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lot_occupancy #(.CAPACITY(16)) dut (
    .clk(clk), .reset(reset), .enter(enter), .exit(exit), .clr_err(clr_err),
    .count(count), .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
    .peak(peak), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
  );

  lot_occupancy #(.CAPACITY(3)) dut3 (
    .clk(clk), .reset(reset3), .enter(enter3), .exit(exit3), .clr_err(clr3),
    .count(count3), .full(full3), .empty(empty3), .ovf_err(ovf3), .unf_err(unf3),
    .peak(peak3), .bcd_tens(tens3), .bcd_ones(ones3)
  );

  // One cycle: inputs were set at a negedge, the posedge samples them, outputs read here.
  task automatic step(input logic e, input logic x, input logic c, input logic r);
    reset = r; enter = e; exit = x; clr_err = c;
    @(negedge clk);
    reset = 1'b0; enter = 1'b0; exit = 1'b0; clr_err = 1'b0;
  endtask

  task automatic step3(input logic e, input logic x, input logic c, input logic r);
    reset3 = r; enter3 = e; exit3 = x; clr3 = c;
    @(negedge clk);
    reset3 = 1'b0; enter3 = 1'b0; exit3 = 1'b0; clr3 = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count, peak, bcd_tens, bcd_ones, full, empty, ovf_err, unf_err} !== {5'd0, 5'd0, 4'd0, 4'd0, 4'b0100}) begin
      failures++;
      $display("FAIL reset_state: count=%0d peak=%0d bcd=%0d/%0d full=%b empty=%b ovf=%b unf=%b required all zero with empty=1",
               count, peak, bcd_tens, bcd_ones, full, empty, ovf_err, unf_err);
    end
    $display("reset: count=%0d empty=%b", count, empty);
  endtask

  task automatic test_enter_sequence();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i)) begin
        failures++;
        $display("FAIL enter_count_%0d: count=%0d required %0d", i, count, i);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      $display("enter %0d: count=%0d", i, count);
    end
    checks++;
    if ({bcd_tens, bcd_ones, empty, peak} !== {4'd0, 4'd3, 1'b0, 5'd3}) begin
      failures++;
      $display("FAIL enter_status: bcd=%0d/%0d empty=%b peak=%0d required 0/3 0 3",
               bcd_tens, bcd_ones, empty, peak);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 5'(i)) begin
        failures++;
        $display("FAIL back_to_back_%0d: count=%0d required %0d", i, count, i);
      end
      $display("b2b enter %0d: count=%0d", i, count);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({count, unf_err, empty, ovf_err} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL underflow: count=%0d unf=%b empty=%b ovf=%b required 0 1 1 0",
               count, unf_err, empty, ovf_err);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, unf_err} !== {5'd1, 1'b1}) begin
      failures++;
      $display("FAIL unf_sticky: count=%0d unf=%b required 1 1", count, unf_err);
    end
    $display("underflow: count=%0d unf=%b", count, unf_err);
  endtask

  task automatic test_bcd();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ((int'(bcd_tens) * 10 + int'(bcd_ones)) != i || bcd_ones > 4'd9) begin
        failures++;
        $display("FAIL bcd_up_%0d: bcd=%0d/%0d required value %0d", i, bcd_tens, bcd_ones, i);
      end
    end
    checks++;
    if ({bcd_tens, bcd_ones} !== {4'd1, 4'd2}) begin
      failures++;
      $display("FAIL bcd_12: bcd=%0d/%0d required 1/2", bcd_tens, bcd_ones);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({count, bcd_tens, bcd_ones, peak} !== {5'd7, 4'd0, 4'd7, 5'd12}) begin
      failures++;
      $display("FAIL bcd_down: count=%0d bcd=%0d/%0d peak=%0d required 7 0/7 12",
               count, bcd_tens, bcd_ones, peak);
    end
    $display("bcd: count=%0d bcd=%0d/%0d peak=%0d", count, bcd_tens, bcd_ones, peak);
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({count, ovf_err, unf_err, empty} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL both_at_empty: count=%0d ovf=%b unf=%b empty=%b required 0 0 0 1",
               count, ovf_err, unf_err, empty);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, full, bcd_tens, bcd_ones} !== {5'd16, 1'b1, 4'd1, 4'd6}) begin
      failures++;
      $display("FAIL fill_16: count=%0d full=%b bcd=%0d/%0d required 16 1 1/6",
               count, full, bcd_tens, bcd_ones);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({count, ovf_err, unf_err, full} !== {5'd16, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL both_at_full: count=%0d ovf=%b unf=%b full=%b required 16 0 0 1",
               count, ovf_err, unf_err, full);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, ovf_err, peak} !== {5'd16, 1'b1, 5'd16}) begin
      failures++;
      $display("FAIL ovf_16: count=%0d ovf=%b peak=%0d required 16 1 16", count, ovf_err, peak);
    end
    $display("simultaneous: count=%0d ovf=%b", count, ovf_err);
  endtask

  task automatic test_overflow_cap3();
    step3(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step3(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count3, full3, ovf3, tens3, ones3} !== {2'd3, 1'b1, 1'b1, 4'd0, 4'd3}) begin
      failures++;
      $display("FAIL cap3_ovf: count=%0d full=%b ovf=%b bcd=%0d/%0d required 3 1 1 0/3",
               count3, full3, ovf3, tens3, ones3);
    end
    step3(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({count3, ovf3, peak3} !== {2'd3, 1'b0, 2'd3}) begin
      failures++;
      $display("FAIL cap3_clr: count=%0d ovf=%b peak=%0d required 3 0 3", count3, ovf3, peak3);
    end
    step3(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({count3, ovf3} !== {2'd3, 1'b1}) begin
      failures++;
      $display("FAIL cap3_set_wins: count=%0d ovf=%b required 3 1", count3, ovf3);
    end
    $display("cap3: count=%0d ovf=%b", count3, ovf3);
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, unf_err} !== {5'd5, 1'b1}) begin
      failures++;
      $display("FAIL pre_midreset: count=%0d unf=%b required 5 1", count, unf_err);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({count, peak, ovf_err, unf_err, empty, bcd_ones} !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL mid_reset: count=%0d peak=%0d ovf=%b unf=%b empty=%b ones=%0d required 0 0 0 0 1 0",
               count, peak, ovf_err, unf_err, empty, bcd_ones);
    end
    $display("mid reset: count=%0d peak=%0d", count, peak);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; exit = 1'b0; clr_err = 1'b0;
    reset3 = 1'b1; enter3 = 1'b0; exit3 = 1'b0; clr3 = 1'b0;
    @(negedge clk);
    test_reset();
    test_enter_sequence();
    test_back_to_back();
    test_underflow();
    test_bcd();
    test_simultaneous();
    test_overflow_cap3();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
